// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One start pulse in IDLE yields a single div_ready pulse with the result and writeback request.
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic            start,
    input  logic [3:0]      div_op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            div_ready,
    output logic [XLEN-1:0] result,
    output logic            reg_we_out,
    output logic [4:0]      rd_out
);

    localparam logic [3:0] OP_DIV  = 4'd1;
    localparam logic [3:0] OP_DIVU = 4'd2;
    localparam logic [3:0] OP_REM  = 4'd3;
    localparam logic [3:0] OP_REMU = 4'd4;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dsor_q, dsor_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [4:0]      count_q, count_d;
    logic [4:0]      rd_q, rd_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic            is_rem_q, is_rem_d;

    logic            accept;
    logic            is_signed;
    logic            is_rem;
    logic            dividend_neg;
    logic            divisor_neg;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;

    always_comb begin
        // NOTE: every _d defaults to its _q first, so no path through the case can infer a latch.
        state_d   = state_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dsor_d    = dsor_q;
        result_d  = result_q;
        count_d   = count_q;
        rd_d      = rd_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        is_rem_d  = is_rem_q;

        accept       = start && (div_op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU});
        is_signed    = (div_op == OP_DIV) || (div_op == OP_REM);
        is_rem       = (div_op == OP_REM) || (div_op == OP_REMU);
        dividend_neg = is_signed && dividend[XLEN-1];
        divisor_neg  = is_signed && divisor[XLEN-1];
        // 33-bit trial subtraction: the top bit is the borrow.
        shifted      = {rem_q, quo_q[XLEN-1]};
        diff         = shifted - {1'b0, dsor_q};

        if (run) begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        rd_d     = rd_in;
                        is_rem_d = is_rem;
                        if (divisor == '0) begin
                            result_d = is_rem ? dividend : {XLEN{1'b1}};
                            state_d  = DONE;
                        end else if (is_signed && dividend == {1'b1, {(XLEN-1){1'b0}}}
                                     && divisor == {XLEN{1'b1}}) begin
                            result_d = is_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}};
                            state_d  = DONE;
                        end else begin
                            rem_d     = '0;
                            quo_d     = dividend_neg ? -dividend : dividend;
                            dsor_d    = divisor_neg ? -divisor : divisor;
                            neg_quo_d = dividend_neg ^ divisor_neg;
                            neg_rem_d = dividend_neg;
                            count_d   = 5'd31;
                            state_d   = CALC;
                        end
                    end
                end
                CALC: begin
                    if (!diff[XLEN]) begin
                        rem_d = diff[XLEN-1:0];
                        quo_d = {quo_q[XLEN-2:0], 1'b1};
                    end else begin
                        rem_d = shifted[XLEN-1:0];
                        quo_d = {quo_q[XLEN-2:0], 1'b0};
                    end
                    count_d = count_q - 5'd1;
                    if (count_q == 5'd0) state_d = FIX;
                end
                FIX: begin
                    if (is_rem_q) result_d = neg_rem_q ? -rem_q : rem_q;
                    else          result_d = neg_quo_q ? -quo_q : quo_q;
                    state_d = DONE;
                end
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (reset) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            quo_q     <= '0;
            dsor_q    <= '0;
            result_q  <= '0;
            count_q   <= '0;
            rd_q      <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            is_rem_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dsor_q    <= dsor_d;
            result_q  <= result_d;
            count_q   <= count_d;
            rd_q      <= rd_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            is_rem_q  <= is_rem_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign div_ready  = (state_q == DONE);
    assign reg_we_out = div_ready && (rd_q != 5'd0);
    assign result     = result_q;
    assign rd_out     = rd_q;

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative RV32M divider for DIV/DIVU/REM/REMU; the execute-side responder to the decoder's divide hazard.
- Accepts operands and op on a one-cycle start pulse, then runs a radix-2 restoring division.
- Returns one ready pulse carrying the result plus the register-writeback request (rd, we).
- The ready pulse releases the decoder's divide stall and feeds the register-file write port.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- run  input  1  core run enable; low freezes all state except reset
- start  input  1  one-cycle request pulse; sampled only in IDLE
- div_op  input  4  DIV_NOP=0, DIV=1, DIVU=2, REM=3, REMU=4; other codes are treated as NOP
- dividend  input  32  rs1 value (decoder alu_a)
- divisor  input  32  rs2 value (decoder alu_b)
- rd_in  input  5  destination register
- busy  output  1  high from the cycle after an accepted start through the ready cycle
- div_ready  output  1  one-cycle pulse; result valid in that cycle
- result  output  32  quotient or remainder; holds its value until the next ready
- reg_we_out  output  1  equals div_ready && (rd_out != 0)
- rd_out  output  5  captured rd; held until the next accept

Behaviour:
- Reset: IDLE; busy=0, div_ready=0, reg_we_out=0, result=0, rd_out=0; internal counters cleared.
- Reset mid-operation: abort immediately; no ready or write is ever produced for the aborted op.
- Accept condition: IDLE && run && start && div_op in {1..4}. Capture op, operands and rd_in; set signed = (DIV or REM).
- Start with NOP/invalid op, or any start outside IDLE: ignored, no response.
- States: IDLE, CALC, FIX, DONE.
- Special-case path: IDLE -> DONE. Taken when divisor==0, or when signed && dividend==0x80000000 && divisor==0xFFFFFFFF.
  - Divide by zero: quotient = 0xFFFFFFFF (both signednesses), remainder = dividend.
  - Overflow: quotient = 0x80000000, remainder = 0.
- Normal path: IDLE -> CALC.
  - On entry: form magnitudes (abs value if signed); remainder register = 0; count = 31.
  - CALC, one bit per cycle, 32 cycles: shift {rem,quo} left 1; if shifted rem >= |divisor|, subtract and set quo LSB. Use a 33-bit subtraction to detect the borrow.
  - CALC -> FIX after the count==0 iteration.
- FIX: if signed, quotient negated when the operand signs differ; remainder takes the dividend's sign. Select quotient (DIV/DIVU) or remainder (REM/REMU). Then -> DONE.
- DONE: div_ready=1 and reg_we_out per rule for exactly one cycle; result updated at entry to DONE. Then -> IDLE.
- Latency (start in cycle 0, run held high):
  - normal path: div_ready in cycle 34;
  - special-case path: div_ready in cycle 1.
- A new start is acceptable in the cycle after ready (back-to-back).
- run low: FSM and counter hold. If in DONE, div_ready stays high until run returns, then drops after one run-high cycle. Ready is never lost or duplicated.
- Outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- DIV 7 / -2 (0x00000007, 0xFFFFFFFE), rd=5, start at cycle 0 -> div_ready only in cycle 34; result=0xFFFFFFFD; rd_out=5; reg_we_out=1. Same operands with REM -> result=0x00000001.
- DIVU 0xFFFFFFFF / 3 -> 0x55555555. REMU 0xFFFFFFFF / 3 -> 0. REM -7 / 2 -> 0xFFFFFFFF. DIV with rd=0 -> div_ready=1, reg_we_out=0.
- DIV 5 / 0 -> result 0xFFFFFFFF, ready in cycle 1. REM 5 / 0 -> 5. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM of same operands -> 0.
- Start pulses with different operands in cycles 5 and 20 of a busy op -> ignored; single ready in cycle 34 with the original result. A new start in cycle 35 is accepted, ready in cycle 69.
- Reset asserted in cycle 10 of a normal op -> cycle 11 shows busy=0; no div_ready in cycles 11..40. A fresh DIVU 100/7 then returns 14 with the normal latency.
- run dropped in cycles 10-14 mid-CALC -> ready delayed to cycle 39, result unchanged. run low during DONE -> ready held until run returns, deasserted after exactly one run-high cycle.
